// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default sizes for the memory arbiter slice.
//   state_e : arbiter FSM states (IDLE, BUSY)
//   owner_e : which requester holds the memory (OWN_FETCH = 0, OWN_LS = 1)
//   DEF_ADDR_W / DEF_DATA_W : default bus widths (64, matching the PC)
//   LAT_CNT_W / STARVE_W    : widths of the latency and starvation counters
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;
  localparam int LAT_CNT_W  = 4;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LS    = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, load/store and Memory-side signals of
// the arbiter.
//   slave  modport : the arbiter (takes requests and mem_rdata, drives grants,
//                    read data, Memory command and pc_stall)
//   master modport : the environment (requesters plus Memory)
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // load/store side
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  // PC hold
  logic              pc_stall;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, pc_stall
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, pc_stall
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// mem_lat_timer: loadable 4-bit down-counter that times the Memory command
// window.
//   clk, reset : clock and synchronous active-high reset
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load (window length minus one)
//   done_o     : count has reached zero
module mem_lat_timer
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  output logic                 done_o
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port Memory between instruction fetch and
// load/store. One transaction at a time: grant in IDLE, hold the Memory
// command for MEM_LAT cycles in BUSY, then return read data to the owner with
// a one-cycle rvalid pulse.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave (fetch req/gnt/rvalid/rdata, load/store
//                req/we/addr/wdata/gnt/rvalid/rdata, Memory addr/wdata/read/
//                write/rdata, pc_stall)
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let fetch win a
// simultaneous request after STARVE_MAX consecutive load/store grants made
// while fetch was waiting. Without it load/store always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;

  logic if_gnt, ls_gnt;
  logic timer_load, timer_done;
  logic fetch_first;

  mem_lat_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (LAT_LOAD),
    .done_o     (timer_done)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign fetch_first = (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (ls_gnt && bus.if_req && (starve_q != '1)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // STARVE_MAX only matters when the guard is built in.
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign fetch_first       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    timer_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A grant seen during reset would be lost, so none is issued then.
        if (!reset) begin
          if (bus.ls_req && !(bus.if_req && fetch_first)) begin
            ls_gnt      = 1'b1;
            owner_d     = OWN_LS;
            we_d        = bus.ls_we;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
          end else if (bus.if_req) begin
            if_gnt     = 1'b1;
            owner_d    = OWN_FETCH;
            we_d       = 1'b0;
            mem_addr_d = bus.if_addr;
          end
        end
        if (if_gnt || ls_gnt) begin
          state_d     = BUSY;
          timer_load  = 1'b1;
          mem_read_d  = ~we_d;
          mem_write_d = we_d;
        end
      end
      BUSY: begin
        if (timer_done) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (owner_q == OWN_LS) begin
              ls_rdata_d  = bus.mem_rdata;
              ls_rvalid_d = 1'b1;
            end else begin
              if_rdata_d  = bus.mem_rdata;
              if_rvalid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.pc_stall  = bus.if_req & ~if_gnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller that shares the single-port `Memory` between the instruction-fetch path (PC/Adder) and the load/store path. It accepts requests from both sides and grants one transaction at a time. It drives `Memory` address, data and read/write strobes for a fixed latency window, then returns read data to the owner with a one-cycle valid pulse. It also raises `pc_stall` whenever fetch is waiting, so the PC register holds.

## Interface
Parameters:
- `ADDR_W`, 64, address width (matches PC width)
- `DATA_W`, 64, data width (matches `Memory` DataIn/DataOut)
- `MEM_LAT`, 1, cycles the memory command is held before read data is sampled; legal 1..15
- `STARVE_MAX`, 4, consecutive load/store grants allowed while fetch is pending (guard enabled only)

Ports:
- Reset is synchronous and active-high; one clock domain.
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous active-high reset
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word
- `ls_req`  in  1  load/store request; held until `ls_gnt`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_gnt`  out  1  load/store request accepted this cycle
- `ls_rvalid`  out  1  one-cycle pulse, loads only
- `ls_rdata`  out  DATA_W  loaded word
- `mem_addr`  out  ADDR_W  to `Memory` address
- `mem_wdata`  out  DATA_W  to `Memory` DataIn
- `mem_read`  out  1  to `Memory` read enable
- `mem_write`  out  1  to `Memory` write enable
- `mem_rdata`  in  DATA_W  from `Memory` DataOut
- `pc_stall`  out  1  `if_req & ~if_gnt`

## Operation
- FSM states: IDLE, BUSY. Owner register records which requester holds BUSY: FETCH or LS.
- IDLE with any request: grant is combinational. `if_gnt` and `ls_gnt` are never high together. The FSM latches owner, address, wdata and we, then moves to BUSY.
- Priority: LS wins a simultaneous request unless the starvation guard forces FETCH (see Configuration).
- BUSY:
  - `mem_addr`/`mem_wdata` are registered from the latched values.
  - `mem_read` = ~we; `mem_write` = we.
  - Both are held for exactly MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT-1.
- At the end of the last BUSY cycle:
  - `mem_rdata` is registered into the owner's rdata.
  - The owner's rvalid pulses next cycle (loads/fetches only; stores give no pulse).
  - The FSM returns to IDLE.
- Grants are accepted only in IDLE. Requests arriving during BUSY wait; `pc_stall` stays high for fetch.
- `if_rdata`/`ls_rdata` hold their last value until the next read by the same owner.

## Timing
- Grant at cycle T.
- Strobes active T+1 .. T+MEM_LAT.
- rvalid at T+MEM_LAT+1, coincident with IDLE, so the next grant is possible in that same cycle.
- Throughput: one transaction per MEM_LAT+1 cycles.
- Reset values: all outputs 0, state IDLE, owner FETCH, starve counter 0.
- Reset mid-BUSY: the transaction is dropped, strobes deassert next cycle, and no rvalid is issued.
- Request deasserted illegally during BUSY: ignored; the transaction completes.
- `if_req` and `ls_req` both held continuously with guard off: fetch starves. This is the specified behaviour.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each LS grant made while `if_req` is high, and clears on any FETCH grant.
  - When the counter equals STARVE_MAX, FETCH wins the next simultaneous request.
- Macro undefined:
  - Strict LS priority.
  - Counter and STARVE_MAX logic absent.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE, BUSY)
  - owner encoding (OWN_FETCH = 0, OWN_LS = 1)
  - default widths (64)
- One sub-module `mem_lat_timer`: loadable down-counter with `load`, `done` outputs, width 4.

## Test plan
- Reset, then single fetch `if_addr`=8, memory returns 0x1234, MEM_LAT=1 -> `if_gnt` at T, `mem_read`=1/`mem_addr`=8 at T+1, `if_rvalid`=1 with `if_rdata`=0x1234 at T+2.
- Store `ls_addr`=16, `ls_wdata`=0xAB -> `mem_write`=1 for one cycle with those values; no `ls_rvalid`.
- `if_req` and `ls_req` together in IDLE -> `ls_gnt` first; `pc_stall`=1 until `if_gnt` two cycles later.
- Guard enabled, STARVE_MAX=4, both requests held -> grant order LS, LS, LS, LS, FETCH, LS...; guard disabled -> LS only.
- MEM_LAT=3 load -> strobes for 3 cycles, `ls_rvalid` at T+4.
- `reset` asserted at T+1 of a load -> strobes 0 at T+2, no `ls_rvalid`, state IDLE.
